// File: rtl/dsm_rx_pkg.sv
// Shared types and constants for the delta-sigma pulse-density receiver.
// Also holds sat_scale, which maps the window pulse count onto the output value width.
package dsm_rx_pkg;

  localparam int unsigned LINES_DEF    = 6;
  localparam int unsigned WIN_LOG2_DEF = 10;
  localparam int unsigned VAL_W_DEF    = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A full window (every sample high) saturates to all-ones; otherwise the low
  // WIN_LOG2-VAL_W bits of the count are dropped. VAL_W must stay below 32.
  function automatic logic [31:0] sat_scale(input logic [31:0] acc,
                                            input int unsigned win_log2,
                                            input int unsigned val_w);
    logic [31:0] full;
    logic [31:0] ones;
    full = 32'd1 << win_log2;
    ones = (32'd1 << val_w) - 32'd1;
    if (acc >= full) sat_scale = ones;
    else             sat_scale = (acc >> (win_log2 - val_w)) & ones;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dsm_rx_demod.sv
// Delta-sigma receiver: counts pulse density on the split pulse bus over fixed windows.
// Optional min/max tracking of emitted values is enabled by defining DSM_RX_PEAK_EN.
module dsm_rx_demod
  import dsm_rx_pkg::*;
#(
  parameter int unsigned LINES    = LINES_DEF,
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
  parameter int unsigned VAL_W    = VAL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LINES-1:0] jb_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_val,
  output logic [LINES-1:0] out_pat,
  output logic             out_err,
  output logic             overrun,
  output logic [VAL_W-1:0] val_min,
  output logic [VAL_W-1:0] val_max
);

  logic [LINES-1:0] jb_sync;

  for (genvar g = 0; g < LINES; g++) begin : g_sync
    sync_2ff u_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (jb_in[g]),
      .q_o   (jb_sync[g])
    );
  end

  state_t              state_q, state_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_LOG2:0]   acc_q, acc_d;
  logic [LINES-1:0]    pat_q, pat_d;
  logic [LINES-1:0]    first_q, first_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic [VAL_W-1:0]    out_val_q, out_val_d;
  logic [LINES-1:0]    out_pat_q, out_pat_d;
  logic                out_err_q, out_err_d;
  logic                overrun_q, overrun_d;

  // Window state including the current sample, so the final sample reaches the result.
  logic                s;
  logic [WIN_LOG2:0]   acc_nx;
  logic [LINES-1:0]    pat_nx;
  logic [LINES-1:0]    first_nx;
  logic                err_nx;
  logic [VAL_W-1:0]    val_nx;
  logic                load;

  assign s        = |jb_sync;
  assign acc_nx   = acc_q + (WIN_LOG2 + 1)'(s);
  assign pat_nx   = s ? (pat_q | jb_sync) : pat_q;
  assign first_nx = (s && (first_q == '0)) ? jb_sync : first_q;
  assign err_nx   = err_q | (s && (first_q != '0) && (jb_sync != first_q));
  assign val_nx   = VAL_W'(sat_scale(32'(acc_nx), WIN_LOG2, VAL_W));

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    pat_d       = pat_q;
    first_d     = first_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_val_d   = out_val_q;
    out_pat_d   = out_pat_q;
    out_err_d   = out_err_q;
    overrun_d   = overrun_q;
    load        = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        acc_d     = '0;
        pat_d     = '0;
        first_d   = '0;
        err_d     = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en || (win_cnt_q == '1)) begin
          // A dropped enable discards the partial window; a window end restarts at once.
          load      = en;
          state_d   = en ? RUN : IDLE;
          win_cnt_d = '0;
          acc_d     = '0;
          pat_d     = '0;
          first_d   = '0;
          err_d     = '0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_LOG2'(1);
          acc_d     = acc_nx;
          pat_d     = pat_nx;
          first_d   = first_nx;
          err_d     = err_nx;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_val_d   = val_nx;
      out_pat_d   = pat_nx;
      out_err_d   = err_nx;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      pat_q       <= '0;
      first_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_pat_q   <= '0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      pat_q       <= pat_d;
      first_q     <= first_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_val_q   <= out_val_d;
      out_pat_q   <= out_pat_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_val   = out_val_q;
  assign out_pat   = out_pat_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;

`ifdef DSM_RX_PEAK_EN
  logic [VAL_W-1:0] min_q, min_d;
  logic [VAL_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (state_q == IDLE) begin
      min_d = '1;
      max_d = '0;
    end else if (load) begin
      if (val_nx < min_q) min_d = val_nx;
      if (val_nx > max_q) max_d = val_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign val_min = min_q;
  assign val_max = max_q;
`else
  assign val_min = '0;
  assign val_max = '0;
`endif

endmodule

// File: tb/tb_dsm_rx_demod.sv
// Bench for dsm_rx_demod: table of window patterns plus random windows, scored against
// a window-level pulse-density model; hand sequences cover overrun, reset, enable and peaks.
module tb_dsm_rx_demod;

  localparam int WIN = 1024;
  localparam int VW  = 10;

  localparam int M_CONST = 0;
  localparam int M_ALT   = 1;
  localparam int M_HALF  = 2;
  localparam int M_COUNT = 3;
  localparam int M_RAND  = 4;

  typedef struct {
    int         mode;
    logic [5:0] a;
    logic [5:0] b;
    int         k;
    bit         has_exp;
    int         ev;
    int         ep;
    int         ee;
  } vec_t;

  typedef struct {
    int v;
    int p;
    int e;
  } res_t;

  logic       clk = 1'b0;
  logic       rst, en, out_ready;
  logic [5:0] jb_in;
  logic       out_valid, out_err, overrun;
  logic [5:0] out_pat;
  logic [9:0] out_val, val_min, val_max;

  always #5 clk = ~clk;

  dsm_rx_demod #(.LINES(6), .WIN_LOG2(10), .VAL_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .jb_in     (jb_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_pat   (out_pat),
    .out_err   (out_err),
    .overrun   (overrun),
    .val_min   (val_min),
    .val_max   (val_max)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   run_s = 0;
  int   nwin = 0;
  int   words = 0;
  bit   mon_on = 1'b0;
  vec_t vecs [0:11];
  int   wrow [0:63];
  logic [5:0] hist [0:65535];

  // hist[e] is the bus value seen at clock edge e
  always @(posedge clk) begin
    if (cyc < 65536) hist[cyc] = jb_in;
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Window result from the raw bus samples: density scaled to VW bits, OR of lines,
  // and whether any active sample differed from the first active one.
  function automatic res_t model(input int start);
    res_t       r;
    int         cnt;
    logic [5:0] pat, first, x;
    bit         err;
    cnt = 0; pat = '0; first = '0; err = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      x = hist[start + i];
      if (x != 6'd0) begin
        cnt++;
        pat |= x;
        if (first == 6'd0) first = x;
        else if (x != first) err = 1'b1;
      end
    end
    r.v = (cnt * (1 << VW)) / WIN;
    if (r.v > (1 << VW) - 1) r.v = (1 << VW) - 1;
    r.p = int'(pat);
    r.e = int'(err);
    return r;
  endfunction

  function automatic logic [5:0] gen(input vec_t v, input int i);
    case (v.mode)
      M_CONST: return v.a;
      M_ALT:   return (i % 2 == 0) ? v.a : 6'd0;
      M_HALF:  return (i < WIN / 2) ? v.a : v.b;
      M_COUNT: return (i < v.k) ? v.a : 6'd0;
      default: begin
        if ($urandom_range(0, 99) < v.k)
          return ($urandom_range(0, 7) == 0) ? 6'($urandom) : v.a;
        return 6'd0;
      end
    endcase
  endfunction

  // Samples of window w were on the bus at edges run_s-1+WIN*w .. +WIN-1 (2-flop latency).
  int   mw;
  res_t mr;
  always @(negedge clk) begin
    if (mon_on && !rst && out_valid && out_ready) begin
      mw = (cyc - 1 - run_s) / WIN - 1;
      if (mw < 0) begin
        check("word_early", mw, 0);
      end else begin
        mr = model(run_s - 1 + WIN * mw);
        check("word_val", out_val, mr.v);
        check("word_pat", out_pat, mr.p);
        check("word_err", out_err, mr.e);
        if (vecs[wrow[mw]].has_exp) begin
          check("tbl_val", out_val, vecs[wrow[mw]].ev);
          check("tbl_pat", out_pat, vecs[wrow[mw]].ep);
          check("tbl_err", out_err, vecs[wrow[mw]].ee);
        end
      end
      words++;
    end
  end

  task automatic step(input logic [5:0] j);
    jb_in = j;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int row, input bit first);
    if (first) begin
      en   = 1'b0;
      nwin = 0;
    end
    wrow[nwin] = row;
    nwin++;
    for (int i = 0; i < WIN; i++) begin
      if (first && i == 1) begin
        en    = 1'b1;
        run_s = cyc;
      end
      step(gen(vecs[row], i));
    end
  endtask

  task automatic wait_word(input string name, input int exp_n);
    int n;
    n = 0;
    while (!out_valid && n < 3000) begin
      step(6'd0);
      n++;
    end
    check(name, n, exp_n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_val"}, out_val, 0);
    check({tag, "_pat"}, out_pat, 0);
    check({tag, "_err"}, out_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_min"}, val_min, 0);
    check({tag, "_max"}, val_max, 0);
  endtask

  int bad;

  initial begin
    vecs[0]  = '{M_CONST, 6'h03, 6'h00, 0,    1'b1, 1023, 'h03, 0};
    vecs[1]  = '{M_ALT,   6'h20, 6'h00, 0,    1'b1, 512,  'h20, 0};
    vecs[2]  = '{M_CONST, 6'h00, 6'h00, 0,    1'b1, 0,    'h00, 0};
    vecs[3]  = '{M_HALF,  6'h01, 6'h02, 0,    1'b1, 1023, 'h03, 1};
    vecs[4]  = '{M_COUNT, 6'h3f, 6'h00, 1,    1'b1, 1,    'h3f, 0};
    vecs[5]  = '{M_COUNT, 6'h10, 6'h00, 1023, 1'b1, 1023, 'h10, 0};
    vecs[6]  = '{M_RAND,  6'($urandom_range(1, 63)), 6'h00, 30, 1'b0, 0, 0, 0};
    vecs[7]  = '{M_RAND,  6'($urandom_range(1, 63)), 6'h00, 50, 1'b0, 0, 0, 0};
    vecs[8]  = '{M_RAND,  6'($urandom_range(1, 63)), 6'h00, 90, 1'b0, 0, 0, 0};
    vecs[9]  = '{M_COUNT, 6'h04, 6'h00, 100,  1'b1, 100,  'h04, 0};
    vecs[10] = '{M_COUNT, 6'h04, 6'h00, 700,  1'b1, 700,  'h04, 0};
    vecs[11] = '{M_COUNT, 6'h04, 6'h00, 300,  1'b1, 300,  'h04, 0};

    rst = 1'b1; en = 1'b0; out_ready = 1'b1; jb_in = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    step(6'd0);
    step(6'd0);

    // Back-to-back windows from the table, consumer always ready
    mon_on = 1'b1;
    run_window(0, 1'b1);
    for (int r = 1; r < 9; r++) run_window(r, 1'b0);
    repeat (3) step(6'd0);
    check("words_accepted", words, 9);
    check("no_overrun", overrun, 0);

    // Consumer stalls across two window ends
    run_window(0, 1'b1);
    out_ready = 1'b0;
    run_window(1, 1'b0);
    check("held_valid", out_valid, 1);
    check("held_val", out_val, 1023);
    check("held_pat", out_pat, 'h03);
    repeat (3) step(6'd0);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", out_valid, 1);
    check("ovr_val", out_val, 512);
    check("ovr_pat", out_pat, 'h20);
    out_ready = 1'b1;
    repeat (2) step(6'd0);

    // Reset mid-window, then enable dropped mid-window
    mon_on = 1'b0;
    rst = 1'b1;
    step(6'd0);
    check_zero("midrst");
    rst = 1'b0;
    wait_word("rst_to_word", WIN + 1);
    repeat (300) step(6'd0);
    en  = 1'b0;
    bad = 0;
    repeat (1100) begin
      step(6'h3f);
      if (out_valid) bad++;
    end
    check("no_word_en_low", bad, 0);
    en = 1'b1;
    wait_word("en_to_word", WIN + 1);
    repeat (2) step(6'd0);

    // Accept lands on the same edge as the next window end
    mon_on = 1'b1;
    run_window(0, 1'b1);
    out_ready = 1'b0;
    run_window(2, 1'b0);
    step(6'd0);
    out_ready = 1'b1;
    step(6'd0);
    check("coinc_valid", out_valid, 1);
    check("coinc_overrun", overrun, 0);
    check("coinc_val", out_val, 0);
    repeat (2) step(6'd0);

    // Peak tracking over three windows
    run_window(9, 1'b1);
    run_window(10, 1'b0);
    run_window(11, 1'b0);
    repeat (3) step(6'd0);
`ifdef DSM_RX_PEAK_EN
    check("peak_min", val_min, 100);
    check("peak_max", val_max, 700);
`else
    check("peak_min", val_min, 0);
    check("peak_max", val_max, 0);
`endif
    check("final_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
